axi_lite_mem_arbiter: RTL and testbench

- Shares one 128-bit AXI-Lite 4 memory port between the instruction-cache master (I_) and the data-cache master (D_) of the CPU core.
- Sits between the CPU top-level cache bus ports and the memory/bus slave.
- Arbitrates whole transactions: one outstanding read or write at a time, non-preemptive.
- Supports round-robin or fixed-priority policy.

---
 rtl/axi_lite_mem_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_axi_lite_mem_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_mem_arbiter.sv
// Shares one 128-bit AXI-Lite memory port between the I-cache (I_) and D-cache (D_) masters.
// Grants whole transactions one at a time, non-preemptive, round-robin or fixed priority.
module axi_lite_mem_arbiter #(
    parameter bit RR_EN      = 1'b1,
    parameter bit DATA_FIRST = 1'b1,
    localparam int unsigned ADDR_W = 32,
    localparam int unsigned DATA_W = 128,
    localparam int unsigned STRB_W = 16,
    localparam int unsigned MSG_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    // instruction-cache master
    input  logic [ADDR_W-1:0] I_readAddr_addr,
    input  logic              I_readAddr_valid,
    output logic              I_readAddr_ready,
    output logic [DATA_W-1:0] I_readData_data,
    output logic              I_readData_valid,
    input  logic              I_readData_ready,
    input  logic [ADDR_W-1:0] I_writeAddr_addr,
    input  logic              I_writeAddr_valid,
    output logic              I_writeAddr_ready,
    input  logic [DATA_W-1:0] I_writeData_data,
    input  logic [STRB_W-1:0] I_writeData_strb,
    input  logic              I_writeData_valid,
    output logic              I_writeData_ready,
    output logic [MSG_W-1:0]  I_writeResp_msg,
    output logic              I_writeResp_valid,
    input  logic              I_writeResp_ready,
    // data-cache master
    input  logic [ADDR_W-1:0] D_readAddr_addr,
    input  logic              D_readAddr_valid,
    output logic              D_readAddr_ready,
    output logic [DATA_W-1:0] D_readData_data,
    output logic              D_readData_valid,
    input  logic              D_readData_ready,
    input  logic [ADDR_W-1:0] D_writeAddr_addr,
    input  logic              D_writeAddr_valid,
    output logic              D_writeAddr_ready,
    input  logic [DATA_W-1:0] D_writeData_data,
    input  logic [STRB_W-1:0] D_writeData_strb,
    input  logic              D_writeData_valid,
    output logic              D_writeData_ready,
    output logic [MSG_W-1:0]  D_writeResp_msg,
    output logic              D_writeResp_valid,
    input  logic              D_writeResp_ready,
    // memory side
    output logic [ADDR_W-1:0] M_readAddr_addr,
    output logic              M_readAddr_valid,
    input  logic              M_readAddr_ready,
    input  logic [DATA_W-1:0] M_readData_data,
    input  logic              M_readData_valid,
    output logic              M_readData_ready,
    output logic [ADDR_W-1:0] M_writeAddr_addr,
    output logic              M_writeAddr_valid,
    input  logic              M_writeAddr_ready,
    output logic [DATA_W-1:0] M_writeData_data,
    output logic [STRB_W-1:0] M_writeData_strb,
    output logic              M_writeData_valid,
    input  logic              M_writeData_ready,
    input  logic [MSG_W-1:0]  M_writeResp_msg,
    input  logic              M_writeResp_valid,
    output logic              M_writeResp_ready,
    output logic [1:0]        grant
);

    typedef enum logic [2:0] {IDLE, RD_AR, RD_R, WR_AWW, WR_B} state_e;

    state_e     state_q, state_d;
    logic       own_q, own_d;
    logic       last_grant_q, last_grant_d;
    logic       aw_done_q, aw_done_d;
    logic       w_done_q, w_done_d;
    logic [1:0] grant_q, grant_d;

    logic       req_i, req_d, win, win_wr;

    // Owner-selected request-side signals
    logic [ADDR_W-1:0] sel_ar_addr, sel_aw_addr;
    logic [DATA_W-1:0] sel_w_data;
    logic [STRB_W-1:0] sel_w_strb;
    logic              sel_ar_valid, sel_r_ready, sel_aw_valid, sel_w_valid, sel_b_ready;

    // Owner-facing response-side signals before demux
    logic [DATA_W-1:0] o_r_data;
    logic [MSG_W-1:0]  o_b_msg;
    logic              o_ar_ready, o_r_valid, o_aw_ready, o_w_ready, o_b_valid;

    assign req_i = I_readAddr_valid | I_writeAddr_valid;
    assign req_d = D_readAddr_valid | D_writeAddr_valid;

    assign sel_ar_addr  = own_q ? D_readAddr_addr   : I_readAddr_addr;
    assign sel_ar_valid = own_q ? D_readAddr_valid  : I_readAddr_valid;
    assign sel_r_ready  = own_q ? D_readData_ready  : I_readData_ready;
    assign sel_aw_addr  = own_q ? D_writeAddr_addr  : I_writeAddr_addr;
    assign sel_aw_valid = own_q ? D_writeAddr_valid : I_writeAddr_valid;
    assign sel_w_data   = own_q ? D_writeData_data  : I_writeData_data;
    assign sel_w_strb   = own_q ? D_writeData_strb  : I_writeData_strb;
    assign sel_w_valid  = own_q ? D_writeData_valid : I_writeData_valid;
    assign sel_b_ready  = own_q ? D_writeResp_ready : I_writeResp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            own_q        <= 1'b0;
            last_grant_q <= ~DATA_FIRST;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            grant_q      <= 2'b00;
        end else begin
            state_q      <= state_d;
            own_q        <= own_d;
            last_grant_q <= last_grant_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            grant_q      <= grant_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        own_d             = own_q;
        last_grant_d      = last_grant_q;
        aw_done_d         = aw_done_q;
        w_done_d          = w_done_q;
        win               = 1'b0;
        win_wr            = 1'b0;
        M_readAddr_addr   = '0;
        M_readAddr_valid  = 1'b0;
        M_readData_ready  = 1'b0;
        M_writeAddr_addr  = '0;
        M_writeAddr_valid = 1'b0;
        M_writeData_data  = '0;
        M_writeData_strb  = '0;
        M_writeData_valid = 1'b0;
        M_writeResp_ready = 1'b0;
        o_ar_ready        = 1'b0;
        o_r_data          = '0;
        o_r_valid         = 1'b0;
        o_aw_ready        = 1'b0;
        o_w_ready         = 1'b0;
        o_b_msg           = '0;
        o_b_valid         = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_i || req_d) begin
                    // Tie: round-robin away from the last owner, or the fixed favourite
                    if (req_i && req_d) win = RR_EN ? ~last_grant_q : DATA_FIRST;
                    else                win = req_d;
                    win_wr       = win ? D_writeAddr_valid : I_writeAddr_valid;
                    own_d        = win;
                    last_grant_d = win;
                    state_d      = win_wr ? WR_AWW : RD_AR;
                end
            end
            RD_AR: begin
                M_readAddr_addr  = sel_ar_addr;
                M_readAddr_valid = sel_ar_valid;
                o_ar_ready       = M_readAddr_ready;
                if (sel_ar_valid && M_readAddr_ready) state_d = RD_R;
            end
            RD_R: begin
                o_r_data         = M_readData_data;
                o_r_valid        = M_readData_valid;
                M_readData_ready = sel_r_ready;
                if (M_readData_valid && sel_r_ready) state_d = IDLE;
            end
            WR_AWW: begin
                // A completed channel is silenced so it cannot handshake twice
                if (!aw_done_q) begin
                    M_writeAddr_addr  = sel_aw_addr;
                    M_writeAddr_valid = sel_aw_valid;
                    o_aw_ready        = M_writeAddr_ready;
                    aw_done_d         = sel_aw_valid & M_writeAddr_ready;
                end
                if (!w_done_q) begin
                    M_writeData_data  = sel_w_data;
                    M_writeData_strb  = sel_w_strb;
                    M_writeData_valid = sel_w_valid;
                    o_w_ready         = M_writeData_ready;
                    w_done_d          = sel_w_valid & M_writeData_ready;
                end
                if (aw_done_d && w_done_d) state_d = WR_B;
            end
            WR_B: begin
                o_b_msg           = M_writeResp_msg;
                o_b_valid         = M_writeResp_valid;
                M_writeResp_ready = sel_b_ready;
                if (M_writeResp_valid && sel_b_ready) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        grant_d = (state_d == IDLE) ? 2'b00 : (own_d ? 2'b10 : 2'b01);
    end

    assign grant = grant_q;

    // Response demux: the non-owner always sees zeros
    assign I_readAddr_ready  = ~own_q & o_ar_ready;
    assign I_readData_data   = own_q ? '0 : o_r_data;
    assign I_readData_valid  = ~own_q & o_r_valid;
    assign I_writeAddr_ready = ~own_q & o_aw_ready;
    assign I_writeData_ready = ~own_q & o_w_ready;
    assign I_writeResp_msg   = own_q ? '0 : o_b_msg;
    assign I_writeResp_valid = ~own_q & o_b_valid;

    assign D_readAddr_ready  = own_q & o_ar_ready;
    assign D_readData_data   = own_q ? o_r_data : '0;
    assign D_readData_valid  = own_q & o_r_valid;
    assign D_writeAddr_ready = own_q & o_aw_ready;
    assign D_writeData_ready = own_q & o_w_ready;
    assign D_writeResp_msg   = own_q ? o_b_msg : '0;
    assign D_writeResp_valid = own_q & o_b_valid;

endmodule

// File: tb/tb_axi_lite_mem_arbiter.sv
// Scoreboard bench for axi_lite_mem_arbiter: round-robin instance with a behavioural memory,
// plus a fixed-priority instance on an always-ready memory.
module tb_axi_lite_mem_arbiter;
    localparam int LIM    = 100;
    localparam int RD_LAT = 3;

    logic clk, rst;

    logic [31:0]  ar_addr[2];
    logic         ar_valid[2], ar_rdy[2];
    logic [127:0] rd_data[2];
    logic         rd_valid[2], rd_rdy[2];
    logic [31:0]  aw_addr[2];
    logic         aw_valid[2], aw_rdy[2];
    logic [127:0] w_data[2];
    logic [15:0]  w_strb[2];
    logic         w_valid[2], w_rdy[2];
    logic [31:0]  b_msg[2];
    logic         b_valid[2], b_rdy[2];

    logic [31:0]  m_ar_addr, m_aw_addr, m_b_msg;
    logic [127:0] m_r_data, m_w_data;
    logic [15:0]  m_w_strb;
    logic         m_ar_valid, m_ar_ready, m_r_valid, m_r_ready;
    logic         m_aw_valid, m_aw_ready, m_w_valid, m_w_ready, m_b_valid, m_b_ready;
    logic [1:0]   grant;

    logic         fp_i_v, fp_d_v;
    logic [1:0]   fp_grant;
    logic         fp_o1[15];
    logic [31:0]  fp_o32[4];
    logic [127:0] fp_o128[3];
    logic [15:0]  fp_o16;

    logic [34:0]  exp_ord_q[$];
    logic [127:0] exp_rd_q[2][$];
    logic [143:0] exp_w_q[$];
    logic [31:0]  exp_b_q[2][$];
    logic [31:0]  b_msg_cfg;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    axi_lite_mem_arbiter #(.RR_EN(1'b1), .DATA_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst),
        .I_readAddr_addr(ar_addr[0]), .I_readAddr_valid(ar_valid[0]), .I_readAddr_ready(ar_rdy[0]),
        .I_readData_data(rd_data[0]), .I_readData_valid(rd_valid[0]), .I_readData_ready(rd_rdy[0]),
        .I_writeAddr_addr(aw_addr[0]), .I_writeAddr_valid(aw_valid[0]), .I_writeAddr_ready(aw_rdy[0]),
        .I_writeData_data(w_data[0]), .I_writeData_strb(w_strb[0]), .I_writeData_valid(w_valid[0]),
        .I_writeData_ready(w_rdy[0]),
        .I_writeResp_msg(b_msg[0]), .I_writeResp_valid(b_valid[0]), .I_writeResp_ready(b_rdy[0]),
        .D_readAddr_addr(ar_addr[1]), .D_readAddr_valid(ar_valid[1]), .D_readAddr_ready(ar_rdy[1]),
        .D_readData_data(rd_data[1]), .D_readData_valid(rd_valid[1]), .D_readData_ready(rd_rdy[1]),
        .D_writeAddr_addr(aw_addr[1]), .D_writeAddr_valid(aw_valid[1]), .D_writeAddr_ready(aw_rdy[1]),
        .D_writeData_data(w_data[1]), .D_writeData_strb(w_strb[1]), .D_writeData_valid(w_valid[1]),
        .D_writeData_ready(w_rdy[1]),
        .D_writeResp_msg(b_msg[1]), .D_writeResp_valid(b_valid[1]), .D_writeResp_ready(b_rdy[1]),
        .M_readAddr_addr(m_ar_addr), .M_readAddr_valid(m_ar_valid), .M_readAddr_ready(m_ar_ready),
        .M_readData_data(m_r_data), .M_readData_valid(m_r_valid), .M_readData_ready(m_r_ready),
        .M_writeAddr_addr(m_aw_addr), .M_writeAddr_valid(m_aw_valid), .M_writeAddr_ready(m_aw_ready),
        .M_writeData_data(m_w_data), .M_writeData_strb(m_w_strb), .M_writeData_valid(m_w_valid),
        .M_writeData_ready(m_w_ready),
        .M_writeResp_msg(m_b_msg), .M_writeResp_valid(m_b_valid), .M_writeResp_ready(m_b_ready),
        .grant(grant)
    );

    axi_lite_mem_arbiter #(.RR_EN(1'b0), .DATA_FIRST(1'b1)) dut_fp (
        .clk(clk), .rst(rst),
        .I_readAddr_addr(32'h10), .I_readAddr_valid(fp_i_v), .I_readAddr_ready(fp_o1[0]),
        .I_readData_data(fp_o128[0]), .I_readData_valid(fp_o1[1]), .I_readData_ready(1'b1),
        .I_writeAddr_addr(32'h0), .I_writeAddr_valid(1'b0), .I_writeAddr_ready(fp_o1[2]),
        .I_writeData_data(128'h0), .I_writeData_strb(16'h0), .I_writeData_valid(1'b0),
        .I_writeData_ready(fp_o1[3]),
        .I_writeResp_msg(fp_o32[0]), .I_writeResp_valid(fp_o1[4]), .I_writeResp_ready(1'b1),
        .D_readAddr_addr(32'h20), .D_readAddr_valid(fp_d_v), .D_readAddr_ready(fp_o1[5]),
        .D_readData_data(fp_o128[1]), .D_readData_valid(fp_o1[6]), .D_readData_ready(1'b1),
        .D_writeAddr_addr(32'h0), .D_writeAddr_valid(1'b0), .D_writeAddr_ready(fp_o1[7]),
        .D_writeData_data(128'h0), .D_writeData_strb(16'h0), .D_writeData_valid(1'b0),
        .D_writeData_ready(fp_o1[8]),
        .D_writeResp_msg(fp_o32[1]), .D_writeResp_valid(fp_o1[9]), .D_writeResp_ready(1'b1),
        .M_readAddr_addr(fp_o32[2]), .M_readAddr_valid(fp_o1[10]), .M_readAddr_ready(1'b1),
        .M_readData_data(128'h5), .M_readData_valid(1'b1), .M_readData_ready(fp_o1[11]),
        .M_writeAddr_addr(fp_o32[3]), .M_writeAddr_valid(fp_o1[12]), .M_writeAddr_ready(1'b1),
        .M_writeData_data(fp_o128[2]), .M_writeData_strb(fp_o16), .M_writeData_valid(fp_o1[13]),
        .M_writeData_ready(1'b1),
        .M_writeResp_msg(32'h0), .M_writeResp_valid(1'b0), .M_writeResp_ready(fp_o1[14]),
        .grant(fp_grant)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: observed no finish, required finish before 30000 cycles");
        $fatal(1, "timeout");
    end

    function automatic logic [127:0] rdata(input logic [31:0] a);
        return {4{a ^ 32'hA5A5_A5A5}};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural memory: AR accepted per m_ar_ready, read data RD_LAT cycles later; B after AW and W
    logic        s_ar, s_r, s_aw, s_w, s_b, aw_got, w_got;
    logic [31:0] s_ar_addr, rd_addr;
    int          rd_cnt;
    initial begin
        m_r_valid = 1'b0; m_r_data = '0; m_b_valid = 1'b0; m_b_msg = '0;
        rd_cnt = 0; rd_addr = '0; aw_got = 1'b0; w_got = 1'b0;
        forever begin
            @(negedge clk);
            s_ar = m_ar_valid & m_ar_ready;  s_ar_addr = m_ar_addr;
            s_r  = m_r_valid & m_r_ready;
            s_aw = m_aw_valid & m_aw_ready;  s_w = m_w_valid & m_w_ready;
            s_b  = m_b_valid & m_b_ready;
            @(posedge clk); #1;
            if (rst) begin
                m_r_valid = 1'b0; m_r_data = '0; m_b_valid = 1'b0; m_b_msg = '0;
                rd_cnt = 0; aw_got = 1'b0; w_got = 1'b0;
            end else begin
                if (s_r) begin m_r_valid = 1'b0; m_r_data = '0; end
                if (s_b) begin m_b_valid = 1'b0; m_b_msg = '0; end
                if (rd_cnt != 0) begin
                    rd_cnt--;
                    if (rd_cnt == 0) begin m_r_valid = 1'b1; m_r_data = rdata(rd_addr); end
                end
                if (s_ar) begin rd_addr = s_ar_addr; rd_cnt = RD_LAT; end
                if (s_aw) aw_got = 1'b1;
                if (s_w)  w_got  = 1'b1;
                if (aw_got && w_got) begin
                    m_b_valid = 1'b1; m_b_msg = b_msg_cfg; aw_got = 1'b0; w_got = 1'b0;
                end
            end
        end
    end

    // Scoreboard pops and gating checks at every falling edge
    logic [34:0]  e_ord;
    logic [127:0] e_rd;
    logic [143:0] e_w;
    logic [31:0]  e_b;
    always @(negedge clk) begin
        if (!rst) begin
            if (m_ar_valid && m_ar_ready) begin
                e_ord = (exp_ord_q.size() != 0) ? exp_ord_q.pop_front() : '1;
                chk("ar_order", 128'({grant, 1'b0, m_ar_addr}), 128'(e_ord));
            end
            if (m_aw_valid && m_aw_ready) begin
                e_ord = (exp_ord_q.size() != 0) ? exp_ord_q.pop_front() : '1;
                chk("aw_order", 128'({grant, 1'b1, m_aw_addr}), 128'(e_ord));
            end
            if (m_w_valid && m_w_ready) begin
                e_w = (exp_w_q.size() != 0) ? exp_w_q.pop_front() : 'x;
                chk("w_data", m_w_data, e_w[143:16]);
                chk("w_strb", 128'(m_w_strb), 128'(e_w[15:0]));
            end
            for (int m = 0; m < 2; m++) begin
                if (rd_valid[m] && rd_rdy[m]) begin
                    e_rd = (exp_rd_q[m].size() != 0) ? exp_rd_q[m].pop_front() : 'x;
                    chk(m == 0 ? "i_rdata" : "d_rdata", rd_data[m], e_rd);
                end
                if (b_valid[m] && b_rdy[m]) begin
                    e_b = (exp_b_q[m].size() != 0) ? exp_b_q[m].pop_front() : 'x;
                    chk(m == 0 ? "i_bmsg" : "d_bmsg", 128'(b_msg[m]), 128'(e_b));
                end
                if (!grant[m])
                    chk(m == 0 ? "i_gated" : "d_gated",
                        128'({ar_rdy[m], rd_valid[m], aw_rdy[m], w_rdy[m], b_valid[m], |rd_data[m], |b_msg[m]}),
                        128'(0));
            end
            if (grant == 2'b00)
                chk("idle_m_gated",
                    128'({m_ar_valid, m_r_ready, m_aw_valid, m_w_valid, m_b_ready,
                          |m_ar_addr, |m_aw_addr, |m_w_data, |m_w_strb}), 128'(0));
        end
    end

    task automatic do_read(input int m, input logic [31:0] a);
        int n;
        exp_rd_q[m].push_back(rdata(a));
        @(posedge clk); #1;
        ar_addr[m] = a; ar_valid[m] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!ar_rdy[m] && n < LIM);
        chk("ar_timeout", 128'(n >= LIM), 128'(0));
        @(posedge clk); #1;
        ar_valid[m] = 1'b0; ar_addr[m] = '0; rd_rdy[m] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!rd_valid[m] && n < LIM);
        chk("r_timeout", 128'(n >= LIM), 128'(0));
        @(posedge clk); #1;
        rd_rdy[m] = 1'b0;
    endtask

    task automatic do_write(input int m, input logic [31:0] a, input logic [127:0] d, input logic [15:0] s);
        int   n;
        logic ahs, whs;
        exp_w_q.push_back({d, s});
        exp_b_q[m].push_back(b_msg_cfg);
        @(posedge clk); #1;
        aw_addr[m] = a; aw_valid[m] = 1'b1; w_data[m] = d; w_strb[m] = s; w_valid[m] = 1'b1;
        n = 0;
        while ((aw_valid[m] || w_valid[m]) && n < LIM) begin
            @(negedge clk); n++;
            ahs = aw_valid[m] & aw_rdy[m];
            whs = w_valid[m] & w_rdy[m];
            @(posedge clk); #1;
            if (ahs) begin aw_valid[m] = 1'b0; aw_addr[m] = '0; end
            if (whs) begin w_valid[m] = 1'b0; w_data[m] = '0; w_strb[m] = '0; end
        end
        chk("wr_timeout", 128'(n >= LIM), 128'(0));
        b_rdy[m] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!b_valid[m] && n < LIM);
        chk("b_timeout", 128'(n >= LIM), 128'(0));
        @(posedge clk); #1;
        b_rdy[m] = 1'b0;
    endtask

    initial begin
        int n, i_cnt, d_cnt;
        rst = 1'b1;
        for (int m = 0; m < 2; m++) begin
            ar_addr[m] = '0; ar_valid[m] = 1'b0; rd_rdy[m] = 1'b0;
            aw_addr[m] = '0; aw_valid[m] = 1'b0; w_data[m] = '0; w_strb[m] = '0;
            w_valid[m] = 1'b0; b_rdy[m] = 1'b0;
        end
        m_ar_ready = 1'b1; m_aw_ready = 1'b1; m_w_ready = 1'b1;
        fp_i_v = 1'b0; fp_d_v = 1'b0; b_msg_cfg = '0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_grant", 128'(grant), 128'(0));
        chk("rst_m_out", 128'({m_ar_valid, m_r_ready, m_aw_valid, m_w_valid, m_b_ready, |m_ar_addr}), 128'(0));
        chk("rst_fp_grant", 128'(fp_grant), 128'(0));
        @(posedge clk); #1; rst = 1'b0;

        // fixed priority: D requests continuously, I starves until D drops
        @(posedge clk); #1; fp_i_v = 1'b1; fp_d_v = 1'b1;
        i_cnt = 0; d_cnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (fp_grant == 2'b01) i_cnt++;
            if (fp_grant == 2'b10) d_cnt++;
        end
        chk("fp_i_starved", 128'(i_cnt), 128'(0));
        chk("fp_d_served", 128'(d_cnt > 0), 128'(1));
        n = 0;
        while (fp_grant != 2'b00 && n < LIM) begin @(negedge clk); n++; end
        fp_d_v = 1'b0;
        @(negedge clk);
        chk("fp_i_after_drop", 128'(fp_grant), 128'(2'b01));
        fp_i_v = 1'b0;

        // single I read: one arbitration cycle, then grant, data 3 cycles after AR
        exp_ord_q.push_back({2'b01, 1'b0, 32'h40});
        exp_rd_q[0].push_back(rdata(32'h40));
        @(posedge clk); #1; ar_addr[0] = 32'h40; ar_valid[0] = 1'b1;
        @(negedge clk);
        chk("t1_arb_cycle", 128'({grant, ar_rdy[0], m_ar_valid}), 128'(0));
        @(negedge clk);
        chk("t1_grant", 128'(grant), 128'(2'b01));
        chk("t1_m_ar", 128'({m_ar_valid, m_ar_addr}), 128'({1'b1, 32'h40}));
        chk("t1_ar_ready", 128'(ar_rdy[0]), 128'(1));
        @(posedge clk); #1; ar_valid[0] = 1'b0; ar_addr[0] = '0; rd_rdy[0] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!rd_valid[0] && n < LIM);
        chk("t1_r_latency", 128'(n), 128'(RD_LAT + 1));
        @(posedge clk); #1; rd_rdy[0] = 1'b0;
        @(negedge clk);
        chk("t1_back_idle", 128'(grant), 128'(0));

        // round-robin pairs: D first after I, then alternation
        exp_ord_q.push_back({2'b10, 1'b0, 32'h1000});
        exp_ord_q.push_back({2'b01, 1'b0, 32'h2000});
        exp_ord_q.push_back({2'b10, 1'b0, 32'h1010});
        exp_ord_q.push_back({2'b01, 1'b0, 32'h2010});
        fork do_read(1, 32'h1000); do_read(0, 32'h2000); join
        fork do_read(1, 32'h1010); do_read(0, 32'h2010); join
        exp_ord_q.push_back({2'b10, 1'b0, 32'h3000});
        exp_ord_q.push_back({2'b01, 1'b0, 32'h4000});
        exp_ord_q.push_back({2'b10, 1'b0, 32'h5000});
        do_read(1, 32'h3000);
        fork do_read(0, 32'h4000); do_read(1, 32'h5000); join

        // D write-back beats D refill
        b_msg_cfg = 32'h0000_BEEF;
        exp_ord_q.push_back({2'b10, 1'b1, 32'h100});
        exp_ord_q.push_back({2'b10, 1'b0, 32'h200});
        fork
            do_write(1, 32'h100, {4{32'hDEAD_0100}}, 16'hFFFF);
            do_read(1, 32'h200);
        join

        // W completes two cycles before AW
        b_msg_cfg = 32'h0;
        m_aw_ready = 1'b0;
        exp_ord_q.push_back({2'b01, 1'b1, 32'h300});
        fork
            do_write(0, 32'h300, {4{32'h1234_5678}}, 16'h0F0F);
            begin
                n = 0;
                do begin @(negedge clk); n++; end while (!(m_w_valid && m_w_ready) && n < LIM);
                @(posedge clk); #1;
                @(negedge clk);
                chk("t5_w_dropped", 128'({m_w_valid, m_aw_valid, grant}), 128'({1'b0, 1'b1, 2'b01}));
                @(posedge clk); #1; m_aw_ready = 1'b1;
                @(negedge clk);
                chk("t5_still_aww", 128'({m_w_valid, m_aw_valid, m_b_ready | m_b_valid}), 128'({1'b0, 1'b1, 1'b0}));
                @(posedge clk); #1;
                @(negedge clk);
                chk("t5_in_wr_b", 128'({m_w_valid, m_aw_valid, m_b_valid, grant}), 128'({1'b0, 1'b0, 1'b1, 2'b01}));
            end
        join

        // asynchronous reset during RD_R with no read data yet
        exp_ord_q.push_back({2'b01, 1'b0, 32'h600});
        @(posedge clk); #1; ar_addr[0] = 32'h600; ar_valid[0] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!ar_rdy[0] && n < LIM);
        @(posedge clk); #1; ar_valid[0] = 1'b0; ar_addr[0] = '0; rd_rdy[0] = 1'b1;
        @(negedge clk);
        chk("t6_rd_r", 128'({grant, m_r_ready, m_r_valid}), 128'({2'b01, 1'b1, 1'b0}));
        #2 rst = 1'b1;
        #1;
        chk("t6_async_rst", 128'({grant, m_r_ready, m_ar_valid, rd_valid[0], ar_rdy[0]}), 128'(0));
        @(posedge clk); #1; rd_rdy[0] = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        exp_ord_q.push_back({2'b10, 1'b0, 32'h7000});
        exp_ord_q.push_back({2'b01, 1'b0, 32'h8000});
        fork do_read(0, 32'h8000); do_read(1, 32'h7000); join
        @(negedge clk);
        chk("post_rst_idle", 128'(grant), 128'(0));

        chk("sb_drain",
            128'({exp_ord_q.size(), exp_w_q.size(), exp_rd_q[0].size(), exp_rd_q[1].size(),
                  exp_b_q[0].size(), exp_b_q[1].size()}), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
